// File: rtl/mips_cpu_mem_ctrl.sv
// mips_cpu_mem_ctrl: bridges a single-outstanding CPU load/store request onto
// an Avalon-MM master. It handles byte/half/word lane steering, extends load
// data, and aborts a transfer after WAIT_LIMIT consecutive waitrequest cycles.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   req_*               : CPU request (valid/write/size/signed/addr/wdata)
//   req_ready           : high in IDLE; a request is taken on that edge
//   resp_valid          : one-cycle completion pulse
//   resp_rdata/resp_err : result, held until the next response
//   mem_address, memread, memwrite, byteenable, memwritedata,
//   waitrequest, memreaddata : Avalon-MM master side
module mips_cpu_mem_ctrl #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        memread,
  output logic        memwrite,
  output logic [3:0]  byteenable,
  output logic [31:0] memwritedata,
  input  logic        waitrequest,
  input  logic [31:0] memreaddata
);

  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIM_M1 = CW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic [CW-1:0] wait_cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        bad_req;
  logic        timeout;
  logic        bus_on;
  logic [3:0]  be_w;
  logic [31:0] wd_w;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;

  // Misalignment / reserved-size check on the live request, so a bad request
  // skips the bus entirely.
  always_comb begin
    bad_req = 1'b0;
    unique case (req_size)
      2'b00:   bad_req = 1'b0;
      2'b01:   bad_req = req_addr[0];
      2'b10:   bad_req = |req_addr[1:0];
      default: bad_req = 1'b1;
    endcase
  end

  // Abort on the WAIT_LIMIT-th consecutive stalled cycle.
  assign timeout = (state == BUS) && waitrequest && (wait_cnt == LIM_M1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid) state_nxt = bad_req ? RESP : BUS;
      BUS:  if (!waitrequest || timeout) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane steering from the registered request.
  always_comb begin
    be_w = 4'b0000;
    wd_w = req_q.wdata;
    unique case (req_q.size)
      2'b00: begin
        be_w = 4'b0001 << req_q.addr[1:0];
        wd_w = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        be_w = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wd_w = {2{req_q.wdata[15:0]}};
      end
      2'b10: begin
        be_w = 4'b1111;
        wd_w = req_q.wdata;
      end
      default: begin
        be_w = 4'b0000;
        wd_w = req_q.wdata;
      end
    endcase
  end

  // Load extraction and extension.
  always_comb begin
    rd_byte = memreaddata[{req_q.addr[1:0], 3'b000} +: 8];
    rd_half = req_q.addr[1] ? memreaddata[31:16] : memreaddata[15:0];
    ld_data = memreaddata;
    unique case (req_q.size)
      2'b00:   ld_data = {{24{req_q.sgn & rd_byte[7]}}, rd_byte};
      2'b01:   ld_data = {{16{req_q.sgn & rd_half[15]}}, rd_half};
      default: ld_data = memreaddata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q    <= '0;
      wait_cnt <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          req_q    <= '{write: req_write, size: req_size, sgn: req_signed,
                        addr: req_addr, wdata: req_wdata};
          wait_cnt <= '0;
          if (bad_req) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        BUS: begin
          if (!waitrequest) begin
            rdata_q <= req_q.write ? 32'h0 : ld_data;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_on       = (state == BUS);
  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign mem_address  = {req_q.addr[31:2], 2'b00};
  assign memread      = bus_on & ~req_q.write;
  assign memwrite     = bus_on &  req_q.write;
  assign byteenable   = bus_on ? be_w : 4'b0000;
  assign memwritedata = wd_w;

endmodule

// File: tb/tb_mips_cpu_mem_ctrl.sv
// Scoreboard bench for mips_cpu_mem_ctrl: the stimulus pushes the expected
// response, and a negedge monitor pops it whenever resp_valid is seen.
module tb_mips_cpu_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_address, memwritedata;
  logic        memread, memwrite;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] memreaddata = '0;

  mips_cpu_mem_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .memread(memread),
    .memwrite(memwrite), .byteenable(byteenable), .memwritedata(memwritedata),
    .waitrequest(waitrequest), .memreaddata(memreaddata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        mon_e = q.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
      end
    end
  end

  // Issue one request, play waitrequest for 'waits' cycles, check bus fields
  // every strobe cycle, then check latency, pulse width and response hold.
  task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rd, input int waits, input int exp_cyc,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int c;
    int guard;
    @(negedge clk);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wdata; memreaddata = rd;
    waitrequest = (waits > 0);
    q.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge clk);
    #1 req_valid = 1'b0;
    c = 0;
    @(negedge clk);
    while ((memread | memwrite) === 1'b1 && c < 20) begin
      chk({name, "_addr"}, mem_address, {addr[31:2], 2'b00});
      chk({name, "_be"}, {28'b0, byteenable}, {28'b0, exp_be});
      chk({name, "_strobe"}, {30'b0, memread, memwrite}, {30'b0, ~wr, wr});
      if (wr) chk({name, "_wdata"}, memwritedata, exp_wd);
      c++;
      waitrequest = (c <= waits);
      @(negedge clk);
    end
    waitrequest = 1'b0;
    chk({name, "_strobe_cycles"}, c, exp_cyc);
    chk({name, "_resp_latency"}, {31'b0, resp_valid}, 32'd1);
    chk({name, "_idle_be"}, {28'b0, byteenable}, 32'd0);
    @(negedge clk);
    chk({name, "_resp_pulse"}, {31'b0, resp_valid}, 32'd0);
    chk({name, "_rdata_hold"}, resp_rdata, exp_rdata);
    chk({name, "_err_hold"}, {31'b0, resp_err}, {31'b0, exp_err});
    chk({name, "_ready_again"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_strobe", {30'b0, memread, memwrite}, 32'd0);
    chk("rst_be", {28'b0, byteenable}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wd", memwritedata, 32'd0);
    chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    //     name        wr    sz     sg    addr          wdata         memreaddata   wt cyc be       wd            rdata         err
    issue("ldw",       1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'h8899AABB, 0, 1, 4'b1111, 32'h0,        32'h8899AABB, 1'b0);
    issue("ldb_s",     1'b0, 2'b00, 1'b1, 32'h13,       32'h0,        32'h80000000, 0, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0);
    issue("ldb_u",     1'b0, 2'b00, 1'b0, 32'h13,       32'h0,        32'h80000000, 0, 1, 4'b1000, 32'h0,        32'h00000080, 1'b0);
    issue("sth_wait",  1'b1, 2'b01, 1'b0, 32'h22,       32'h1234,     32'hDEADBEEF, 3, 4, 4'b1100, 32'h12341234, 32'h0,        1'b0);
    issue("ldw_mis",   1'b0, 2'b10, 1'b0, 32'h05,       32'h0,        32'h11111111, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1);
    issue("ldw_tmo",   1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        32'h22222222, 100, 4, 4'b1111, 32'h0,      32'h0,        1'b1);
    issue("stb",       1'b1, 2'b00, 1'b0, 32'h01,       32'hFFFFFFA5, 32'h0,        0, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0);
    issue("ldh_s",     1'b0, 2'b01, 1'b1, 32'h02,       32'h0,        32'h80017FFF, 0, 1, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0);
    issue("ldh_u",     1'b0, 2'b01, 1'b0, 32'h100,      32'h0,        32'h1234F00D, 1, 2, 4'b0011, 32'h0,        32'h0000F00D, 1'b0);
    issue("ld_rsvd",   1'b0, 2'b11, 1'b0, 32'h00,       32'h0,        32'h33333333, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1);
    issue("ldh_mis",   1'b0, 2'b01, 1'b0, 32'h03,       32'h0,        32'h44444444, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1);
    issue("ldw_sgn",   1'b0, 2'b10, 1'b1, 32'hABCD0008, 32'h0,        32'h80000000, 0, 1, 4'b1111, 32'h0,        32'h80000000, 1'b0);
    issue("stw",       1'b1, 2'b10, 1'b0, 32'h0C,       32'hCAFEF00D, 32'h0,        2, 3, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0);

    // Reset in the middle of a stalled load.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h80; waitrequest = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_memread", {31'b0, memread}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_memread", {31'b0, memread}, 32'd0);
    chk("async_ready", {31'b0, req_ready}, 32'd1);
    chk("async_addr", mem_address, 32'd0);
    chk("async_be", {28'b0, byteenable}, 32'd0);
    chk("async_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    waitrequest = 1'b0;
    issue("post_rst",  1'b0, 2'b00, 1'b0, 32'h81,       32'h0,        32'h0000C300, 0, 1, 4'b0010, 32'h0,        32'h000000C3, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_cpu_mem_ctrl.md
MIPS_CPU_MEM_CTRL -- requirements
Module: mips_cpu_mem_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 255, giving the maximum consecutive waitrequest cycles before a transfer is aborted.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: CPU requests a transfer.
REQ-005 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-007 The block SHALL have port req_signed, input, 1 bit: sign-extend load result.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data, right-justified.
REQ-010 The block SHALL have port req_ready, output, 1 bit: request accepted this edge.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: extended load data.
REQ-013 The block SHALL have port resp_err, output, 1 bit: misaligned, reserved size or timeout.
REQ-014 The block SHALL have Avalon master ports mem_address (output, 32), memread (output, 1), memwrite (output, 1), byteenable (output, 4), memwritedata (output, 32), waitrequest (input, 1), memreaddata (input, 32).

Function
REQ-015 The block SHALL use FSM states IDLE, BUS, RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-017 A request SHALL be accepted on a rising edge in IDLE with req_valid=1; all req_* fields SHALL be registered at that edge.
REQ-018 An accepted request that is misaligned (half with addr[0]=1, word with addr[1:0]!=0) or has size 11 SHALL go directly to RESP with resp_err=1, resp_rdata=0, and no bus strobe.
REQ-019 Otherwise the block SHALL go to BUS and assert exactly one of memread/memwrite, with mem_address = {addr[31:2],2'b00}.
REQ-020 Byte lanes SHALL be little-endian: byte at offset k -> byteenable = 1<<k; half at offset 0 -> 0011, offset 2 -> 1100; word -> 1111.
REQ-021 memwritedata SHALL replicate the data: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata.
REQ-022 mem_address, byteenable, memwritedata and the strobe SHALL stay stable while waitrequest=1.
REQ-023 A transfer SHALL complete on the first rising edge in BUS where waitrequest=0; load data SHALL be captured at that edge and the FSM SHALL go to RESP.
REQ-024 Load data SHALL be extracted from the selected lane(s) and zero- or sign-extended per req_signed; word loads SHALL ignore req_signed.
REQ-025 A counter SHALL count BUS cycles with waitrequest=1; when it reaches WAIT_LIMIT, the block SHALL deassert the strobe and go to RESP with resp_err=1 and resp_rdata=0.
REQ-026 In RESP, resp_valid SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE; resp_rdata/resp_err SHALL hold until the next response.
REQ-027 Minimum latency SHALL be: accept at edge N, strobe during cycle N..N+1, zero-wait completion at edge N+1, resp_valid high in cycle N+1..N+2, req_ready high again from edge N+2.
REQ-028 Stores SHALL return resp_rdata=0.
REQ-029 Outside BUS, memread, memwrite and byteenable SHALL be 0.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, with memread=memwrite=0, byteenable=0, mem_address=0, memwritedata=0, resp_valid=0, resp_rdata=0, resp_err=0, and the wait counter cleared, including in the middle of a transfer.
REQ-031 After reset is released, the first request SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-032 Word load at addr 0x10, memreaddata=0x8899AABB, waitrequest=0 -> mem_address=0x10, byteenable=1111, resp_rdata=0x8899AABB after 2 cycles.
REQ-033 Signed byte load at addr 0x13, memreaddata=0x80000000 -> byteenable=1000, resp_rdata=0xFFFFFF80; the unsigned variant -> 0x00000080.
REQ-034 Half store at addr 0x22, wdata=0x1234, waitrequest high for 3 cycles -> memwrite held 4 cycles, byteenable=1100, memwritedata=0x12341234, inputs stable throughout.
REQ-035 Word load at addr 0x05 -> no memread, resp_err=1 one cycle after acceptance.
REQ-036 waitrequest held high with WAIT_LIMIT=4 -> strobe dropped after 4 wait cycles, resp_err=1, resp_rdata=0.
REQ-037 reset asserted during BUS -> memread drops asynchronously, req_ready=1 after release, and the next request completes normally.
